// File: rtl/decoder_n_pkg.sv
// ---------------------------------------------------------------------------
// decoder_n_pkg : mode encodings, FSM states and helpers for decoder_n
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package decoder_n_pkg;

   localparam logic [1:0] c_MODE_DIRECT = 2'd0;
   localparam logic [1:0] c_MODE_PULSE  = 2'd1;
   localparam logic [1:0] c_MODE_SCAN   = 2'd2;
   localparam logic [1:0] c_MODE_RSVD   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // The reserved encoding behaves exactly like DIRECT
   function automatic logic [1:0] eff_mode(input logic [1:0] mode);
      return (mode == c_MODE_RSVD) ? c_MODE_DIRECT : mode;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_n_tick_div.sv
// ---------------------------------------------------------------------------
// tick_div : dwell divider, TICK high on every DIV-th enabled cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_div #(
   parameter int DIV = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   input  logic EN,
   output logic TICK
);

   localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

   logic [c_CW-1:0] r_cnt;
   logic            w_last;

   assign w_last = (r_cnt == c_LAST);
   assign TICK   = EN && !CLR && w_last;

   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         r_cnt <= '0;
      end else if (EN) begin
         r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/decoder_n.sv
// ---------------------------------------------------------------------------
// decoder_n : registered one-hot decoder with DIRECT, PULSE and SCAN modes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decoder_n
   import decoder_n_pkg::*;
#(
   parameter int SEL_W    = 3,
   parameter int OUT_W    = 2**SEL_W,
   parameter int SCAN_DIV = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [SEL_W-1:0] SEL,
   input  logic             EN,
   input  logic [1:0]       MODE,
   output logic [OUT_W-1:0] OUT,
   output logic [SEL_W-1:0] IDX,
   output logic             VALID,
   output logic             WRAP
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [OUT_W-1:0] r_out;
   logic [OUT_W-1:0] w_out_nxt;
   logic [SEL_W-1:0] r_idx;
   logic [SEL_W-1:0] w_idx_nxt;
   logic             r_valid;
   logic             r_wrap;
   logic             w_wrap_nxt;
   logic             r_en_hist;
   logic [1:0]       r_mode;

   logic [1:0]       w_mode_eff;
   logic             w_rise;
   logic             w_scan_run;
   logic             w_div_clr;
   logic             w_tick;
   logic [OUT_W-1:0] w_sel_hot;
   logic [SEL_W-1:0] w_idx_inc;

   assign w_mode_eff = eff_mode(MODE);
   // A mode change wipes edge history, so a held EN counts as a fresh rise
   assign w_rise     = EN && (!r_en_hist || (MODE != r_mode));
   assign w_scan_run = EN && (w_mode_eff == c_MODE_SCAN) && (r_state == ST_SCAN) && !w_rise;
   assign w_div_clr  = !w_scan_run;
   assign w_sel_hot  = OUT_W'(1) << SEL;
   assign w_idx_inc  = r_idx + SEL_W'(1);

   tick_div #(
      .DIV (SCAN_DIV)
   ) u_tick_div (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (w_div_clr),
      .EN   (w_scan_run),
      .TICK (w_tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_out     <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_wrap    <= 1'b0;
         r_en_hist <= 1'b0;
         r_mode    <= c_MODE_DIRECT;
      end else begin
         r_state   <= w_state_nxt;
         r_out     <= w_out_nxt;
         r_idx     <= w_idx_nxt;
         r_valid   <= |w_out_nxt;
         r_wrap    <= w_wrap_nxt;
         r_en_hist <= EN;
         r_mode    <= MODE;
      end
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      w_out_nxt   = '0;
      w_idx_nxt   = r_idx;
      w_wrap_nxt  = 1'b0;
      if (EN) begin
         case (w_mode_eff)
            c_MODE_PULSE: begin
               if (w_rise) begin
                  w_state_nxt = ST_ACTIVE;
                  w_out_nxt   = w_sel_hot;
                  w_idx_nxt   = SEL;
               end
            end
            c_MODE_SCAN: begin
               w_state_nxt = ST_SCAN;
               if (!w_scan_run) begin
                  w_out_nxt = w_sel_hot;
                  w_idx_nxt = SEL;
               end else if (w_tick) begin
                  w_out_nxt  = OUT_W'(1) << w_idx_inc;
                  w_idx_nxt  = w_idx_inc;
                  w_wrap_nxt = &r_idx;
               end else begin
                  w_out_nxt = r_out;
               end
            end
            default: begin
               w_state_nxt = ST_ACTIVE;
               w_out_nxt   = w_sel_hot;
               w_idx_nxt   = SEL;
            end
         endcase
      end
   end

   assign OUT   = r_out;
   assign IDX   = r_idx;
   assign VALID = r_valid;
   assign WRAP  = r_wrap;

endmodule

`default_nettype wire
